// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: recovers the duty count of each 64-clock PWM frame
// and rebuilds the slow square-wave envelope.
// It also reports the envelope half-period in frames.
module pwm_duty_decoder (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       Enable,
  input  logic       Pulse_In,
  output logic [6:0] Duty_Out,
  output logic       Duty_Valid,
  output logic       Level,
  output logic [5:0] Half_Period,
  output logic       Locked
);

  logic       s1_q, s2_q, s3_q;
  logic       rise;
  logic [5:0] frm_q, frm_d;
  logic [6:0] hi_q, hi_d;
  logic [6:0] hi_sum;
  logic [5:0] run_q, run_d;
  logic [6:0] duty_q, duty_d;
  logic       valid_q, valid_d;
  logic       level_q, level_d;
  logic [5:0] hp_q, hp_d;
  logic       locked_q, locked_d;
  logic       newlvl;

  // Two-flop synchronizer plus one edge-detect stage; keeps running while disabled
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= Pulse_In;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise   = s2_q & ~s3_q;
  assign hi_sum = hi_q + {6'd0, s2_q};
  assign newlvl = (hi_sum >= 7'd32);

  // Frame counting, realignment and envelope tracking
  always_comb begin
    frm_d    = frm_q;
    hi_d     = hi_q;
    run_d    = run_q;
    duty_d   = duty_q;
    valid_d  = 1'b0;
    level_d  = level_q;
    hp_d     = hp_q;
    locked_d = locked_q;
    if (!Enable) begin
      frm_d    = '0;
      hi_d     = '0;
      run_d    = '0;
      locked_d = 1'b0;
    end else if (rise && (frm_q != 6'd0)) begin
      // The rising sample itself is index 0 of the new frame, so it is already counted
      frm_d    = 6'd1;
      hi_d     = 7'd1;
      locked_d = 1'b0;
    end else if (frm_q == 6'd63) begin
      duty_d   = hi_sum;
      valid_d  = 1'b1;
      frm_d    = '0;
      hi_d     = '0;
      locked_d = 1'b1;
      if (newlvl != level_q) begin
        hp_d    = run_q;
        run_d   = 6'd1;
        level_d = newlvl;
      end else if (run_q != 6'd63) begin
        run_d = run_q + 6'd1;
      end
    end else begin
      frm_d = frm_q + 6'd1;
      hi_d  = hi_sum;
    end
  end

  // State and registered outputs
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      frm_q    <= '0;
      hi_q     <= '0;
      run_q    <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
      level_q  <= 1'b0;
      hp_q     <= '0;
      locked_q <= 1'b0;
    end else begin
      frm_q    <= frm_d;
      hi_q     <= hi_d;
      run_q    <= run_d;
      duty_q   <= duty_d;
      valid_q  <= valid_d;
      level_q  <= level_d;
      hp_q     <= hp_d;
      locked_q <= locked_d;
    end
  end

  assign Duty_Out    = duty_q;
  assign Duty_Valid  = valid_q;
  assign Level       = level_q;
  assign Half_Period = hp_q;
  assign Locked      = locked_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Bench for pwm_duty_decoder: a frame-level reference model built on the
// delayed sample stream and a queue holding the current frame's samples.
module tb_pwm_duty_decoder;

  logic       sysclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       Enable = 1'b0;
  logic       Pulse_In = 1'b0;
  logic [6:0] Duty_Out;
  logic       Duty_Valid;
  logic       Level;
  logic [5:0] Half_Period;
  logic       Locked;

  int n_err = 0;
  int n_checks = 0;

  // Model state
  bit ph[4];
  bit fs[$];
  int m_duty, m_valid, m_level, m_hp, m_run, m_locked;

  pwm_duty_decoder dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .Enable     (Enable),
    .Pulse_In   (Pulse_In),
    .Duty_Out   (Duty_Out),
    .Duty_Valid (Duty_Valid),
    .Level      (Level),
    .Half_Period(Half_Period),
    .Locked     (Locked)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) ph[i] = 1'b0;
    fs.delete();
    m_duty = 0; m_valid = 0; m_level = 0; m_hp = 0; m_run = 0; m_locked = 0;
  endtask

  // One clock edge of the reference: sample is the line value two edges ago
  task automatic model_edge(input bit pin, input bit en);
    bit s, rs;
    int sum;
    ph[3] = ph[2]; ph[2] = ph[1]; ph[1] = ph[0]; ph[0] = pin;
    s  = ph[2];
    rs = ph[2] && !ph[3];
    m_valid = 0;
    if (!en) begin
      fs.delete();
      m_run = 0;
      m_locked = 0;
    end else if (rs && fs.size() != 0) begin
      fs.delete();
      fs.push_back(1'b1);
      m_locked = 0;
    end else if (fs.size() == 63) begin
      fs.push_back(s);
      sum = 0;
      foreach (fs[i]) sum += int'(fs[i]);
      fs.delete();
      m_duty = sum;
      m_valid = 1;
      m_locked = 1;
      if (int'(sum >= 32) != m_level) begin
        m_hp = m_run;
        m_run = 1;
        m_level = int'(sum >= 32);
      end else begin
        m_run = (m_run < 63) ? m_run + 1 : 63;
      end
    end else begin
      fs.push_back(s);
    end
  endtask

  task automatic compare_all();
    chk("duty", int'(Duty_Out), m_duty);
    chk("valid", int'(Duty_Valid), m_valid);
    chk("level", int'(Level), m_level);
    chk("half_period", int'(Half_Period), m_hp);
    chk("locked", int'(Locked), m_locked);
  endtask

  task automatic step(input bit pin, input bit en);
    @(negedge sysclk);
    Pulse_In = pin;
    Enable   = en;
    @(posedge sysclk);
    #1;
    model_edge(pin, en);
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    rst_n = 1'b0;
    #1;
    chk("rst_duty", int'(Duty_Out), 0);
    chk("rst_valid", int'(Duty_Valid), 0);
    chk("rst_level", int'(Level), 0);
    chk("rst_half_period", int'(Half_Period), 0);
    chk("rst_locked", int'(Locked), 0);
    Pulse_In = 1'b0;
    Enable   = 1'b0;
    @(posedge sysclk);
    @(negedge sysclk);
    rst_n = 1'b1;
    model_clear();
  endtask

  // One generator frame: high for the first duty clocks of len clocks
  task automatic pwm_frame(input int duty, input int len, input bit en);
    for (int i = 0; i < len; i++) step(i < duty, en);
  endtask

  initial begin
    int d, l, sel;
    model_clear();
    do_reset();

    // Constant high line
    repeat (200) step(1'b1, 1'b1);
    chk("const_hi_duty", int'(Duty_Out), 64);
    chk("const_hi_level", int'(Level), 1);
    chk("const_hi_locked", int'(Locked), 1);

    // Aligned duty 20
    repeat (6) pwm_frame(20, 64, 1'b1);
    chk("duty20", int'(Duty_Out), 20);
    chk("duty20_level", int'(Level), 0);

    // Phase jumps: rise lands at index 40, then at index 63
    pwm_frame(20, 40, 1'b1);
    repeat (3) pwm_frame(20, 64, 1'b1);
    pwm_frame(20, 63, 1'b1);
    repeat (3) pwm_frame(20, 64, 1'b1);
    chk("jump_locked", int'(Locked), 1);
    chk("jump_duty", int'(Duty_Out), 20);

    // Enable dropped mid-frame, then re-enabled
    pwm_frame(20, 30, 1'b1);
    repeat (50) step(1'($urandom), 1'b0);
    chk("dis_locked", int'(Locked), 0);
    chk("dis_duty_hold", int'(Duty_Out), 20);
    repeat (3) pwm_frame(40, 64, 1'b1);

    // Reset mid-frame
    pwm_frame(20, 25, 1'b1);
    do_reset();

    // Generator square wave: 32 frames full, 32 frames empty, twice
    repeat (2) begin
      repeat (32) pwm_frame(64, 64, 1'b1);
      repeat (32) pwm_frame(0, 64, 1'b1);
    end
    repeat (8) step(1'b0, 1'b1);
    chk("square_half_period", int'(Half_Period), 32);
    chk("square_level", int'(Level), 0);

    // Envelope high longer than 63 frames then low: saturated half-period
    do_reset();
    repeat (70) pwm_frame(64, 64, 1'b1);
    repeat (70) step(1'b0, 1'b1);
    chk("sat_half_period", int'(Half_Period), 63);
    chk("sat_level", int'(Level), 0);

    // Random mix of frames, odd frame lengths, enable drops and resets
    repeat (60) begin
      sel = int'($urandom_range(0, 9));
      d   = int'($urandom_range(0, 64));
      if (sel == 0) begin
        do_reset();
      end else if (sel == 1) begin
        l = int'($urandom_range(1, 80));
        repeat (l) step(1'($urandom), 1'b0);
      end else if (sel == 2) begin
        l = int'($urandom_range(30, 80));
        pwm_frame(d, l, 1'b1);
      end else begin
        pwm_frame(d, 64, 1'b1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_duty_decoder.md
# pwm_duty_decoder

Receive-side counterpart of the square-wave PWM generator. It samples a 64-clock-frame PWM line, recovers the duty count of every frame (0..64) and rebuilds the slow square-wave envelope. It also reports the envelope half-period in frames, so the generator output can be checked or looped back on the same board clock.

## Interface
- No parameters. Frame length is fixed at 64 clocks, matching the generator.
- sysclk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- Enable  in  1  decoder run enable; when low, the decoder is held idle
- Pulse_In  in  1  asynchronous PWM line from the generator
- Duty_Out  out  7  high-sample count of the last completed frame, 0..64
- Duty_Valid  out  1  one-cycle strobe; Duty_Out updated this cycle
- Level  out  1  recovered envelope: 1 when last Duty_Out >= 32
- Half_Period  out  6  frames in the last completed constant-Level run; saturates at 63
- Locked  out  1  1 after one full frame completes without realignment

## Operation
- Synchronizer: two flops, s1 then s2, reset to 0. The sample used is s = s2. A third flop s3 (reset 0) provides the rise term: rise = s2 & ~s3.
- Frame state:
  - frm_cnt[5:0] is the index of the current sample.
  - hi_cnt[6:0] is the count of high samples so far in the frame.
- Per cycle, with Enable = 1, the first matching rule applies:
  1. Realign (rise && frm_cnt != 0):
     - Discard the partial frame.
     - Set frm_cnt <= 1 and hi_cnt <= 1.
     - Set Locked <= 0.
     - No Duty_Valid.
     - Takes priority over frame end, including rise at index 63.
  2. Frame end (frm_cnt == 63):
     - Set Duty_Out <= hi_cnt + s and Duty_Valid <= 1.
     - Set frm_cnt <= 0 and hi_cnt <= 0.
     - Set Locked <= 1.
  3. Otherwise: frm_cnt <= frm_cnt + 1 and hi_cnt <= hi_cnt + s.
- A rise at frm_cnt == 0 is the aligned case and takes rule 3.
- Constant-high and constant-low lines produce no rises. The frame counter free-runs and reports 64 or 0 every 64 cycles.
- Envelope, evaluated only on cycles where Duty_Valid is written 1 (the new value is newlvl = hi_cnt + s >= 32):
  - If newlvl != Level:
    - Set Half_Period <= run_cnt and run_cnt <= 1.
    - Set Level <= newlvl.
  - Otherwise set run_cnt <= min(run_cnt + 1, 63).
  - run_cnt[5:0] resets to 0. Because of that, the first level change after reset reports the frames since reset.
- Enable = 0:
  - Clear frm_cnt, hi_cnt, run_cnt and Locked; force Duty_Valid to 0.
  - Hold Duty_Out, Level and Half_Period.
  - The synchronizer keeps running.
- Width rules:
  - hi_cnt never exceeds 64, so 7 bits are sufficient.
  - Duty_Out = 64 means 100 %.
  - Half_Period saturates at 63 and never wraps.

## Timing
- Reset values: Duty_Out = 0, Duty_Valid = 0, Level = 0, Half_Period = 0, Locked = 0, and all internal state 0.
- Reset asserted mid-frame clears everything immediately. After release, the first frame boundary comes from the first rise, or from 64 cycles of free-running count.
- Pulse_In to s2 latency: 2 clocks.
- Duty_Valid goes high on the clock edge after the index-63 sample is present on s2. That is 3 clocks after Pulse_In holds the last sample of the frame.
- Level, Half_Period and Duty_Out change only on the same edge that raises Duty_Valid.
- Duty_Valid lasts exactly one cycle. Consecutive strobes are 64 cycles apart while aligned.
- Enable rising: counting starts from frm_cnt = 0 on the next edge. The first Duty_Valid comes 64 cycles later, unless a rise realigns first.

## Test plan
- Constant high Pulse_In for 200 cycles after reset: Duty_Out = 64 with Duty_Valid every 64 cycles, Level = 1, Locked = 1 after the first strobe.
- PWM with duty 20, aligned: every strobe shows Duty_Out = 20, Level = 0, and no Locked drop after the first frame.
- Generator square wave (32 frames at 64, then 32 frames at 0, repeating): Level toggles every 32 strobes, and Half_Period = 32 from the second transition onward.
- Phase jump: a rise injected at frm_cnt = 40, including the case at index 63. Locked drops, no strobe for the partial frame, and the next strobe comes 63 cycles after the rise with the correct duty.
- Envelope constant high for more than 63 frames, then low: Half_Period = 63 (saturated).
- rst_n pulsed low mid-frame, and Enable dropped mid-frame: all outputs take their reset values on reset. On Enable low, Locked = 0, no strobe, and the held outputs stay unchanged until re-enable plus 64 cycles.
